// File: rtl/bist_seq_ctrl.sv
// -----------------------------------------------------------------------------
// bist_seq_ctrl
// -----------------------------------------------------------------------------
// Purpose:
//   BIST session sequencer sitting between the test-mode controller and the
//   LFSR/MISR pair wrapped around the circuit under test. One session runs
//   M_SEEDS rounds of N_PAT patterns each. Between rounds it pulses a seed
//   reload. After the last pattern it compares the MISR signature with the
//   golden value and reports PASS or FAIL. A session can be aborted. A new
//   session is armed by the next rising edge of i_start.
//
// Parameters:
//   N_PAT    patterns per round (>= 1)
//   M_SEEDS  rounds per session (>= 1)
//   SIG_W    signature width
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_start      session request (level; acted on at its rising edge)
//   i_abort      stop the session early, sampled every cycle
//   i_signature  MISR output, stable during the o_finish cycle
//   i_golden     expected signature
//   o_init       1-cycle pulse before the first pattern (LFSR/MISR clear)
//   o_running    pattern-apply enable (LFSR/MISR step)
//   o_seed_ld    1-cycle pulse between rounds (load next seed)
//   o_finish     1-cycle pulse after the last pattern (compare cycle)
//   o_bist_end   session over; held until the next o_init
//   o_pass       signature matched (valid while o_bist_end = 1)
//   o_fail       mismatch or aborted (valid while o_bist_end = 1)
//   o_pat_idx    current pattern index
//   o_seed_idx   current round index
// -----------------------------------------------------------------------------
module bist_seq_ctrl #(
    parameter  int N_PAT   = 10,
    parameter  int M_SEEDS = 9,
    parameter  int SIG_W   = 16,
    localparam int PW      = (N_PAT   > 1) ? $clog2(N_PAT)   : 1,
    localparam int SW      = (M_SEEDS > 1) ? $clog2(M_SEEDS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [SIG_W-1:0] i_signature,
    input  logic [SIG_W-1:0] i_golden,
    output logic             o_init,
    output logic             o_running,
    output logic             o_seed_ld,
    output logic             o_finish,
    output logic             o_bist_end,
    output logic             o_pass,
    output logic             o_fail,
    output logic [PW-1:0]    o_pat_idx,
    output logic [SW-1:0]    o_seed_idx
);

    // Terminal counter values; counters stop exactly here and never wrap.
    localparam logic [PW-1:0] PAT_LAST  = PW'(N_PAT - 1);
    localparam logic [SW-1:0] SEED_LAST = SW'(M_SEEDS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_INIT    = 3'd2,
        S_RUN     = 3'd3,
        S_SEED    = 3'd4,
        S_FIN     = 3'd5,
        S_DONE_HI = 3'd6,
        S_DONE_LO = 3'd7
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pat;
    logic [PW-1:0] w_pat_nxt;
    logic [SW-1:0] r_seed;
    logic [SW-1:0] w_seed_nxt;
    logic          w_pass_nxt;
    logic          w_fail_nxt;
    logic          w_sig_match;

    logic          r_init;
    logic          r_running;
    logic          r_seed_ld;
    logic          r_finish;
    logic          r_bist_end;
    logic          r_pass;
    logic          r_fail;

    assign w_sig_match = (i_signature == i_golden);

    // Next-state, counter and verdict computation for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_pat_nxt   = r_pat;
        w_seed_nxt  = r_seed;
        w_pass_nxt  = 1'b0;
        w_fail_nxt  = 1'b0;

        case (r_state)
            // Require START low before arming, so a level held through
            // reset does not launch a session.
            S_IDLE: begin
                if (!i_start) begin
                    w_state_nxt = S_ARM;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            // Counters are cleared on entry to INIT so they read 0 there.
            S_ARM: begin
                if (i_start) begin
                    w_state_nxt = S_INIT;
                    w_pat_nxt   = {PW{1'b0}};
                    w_seed_nxt  = {SW{1'b0}};
                end else begin
                    w_state_nxt = S_ARM;
                end
            end

            S_INIT: begin
                if (i_abort) begin
                    w_state_nxt = S_DONE_HI;
                    w_fail_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end

            // Abort takes priority over the last-pattern decision and
            // freezes both counters.
            S_RUN: begin
                if (i_abort) begin
                    w_state_nxt = S_DONE_HI;
                    w_fail_nxt  = 1'b1;
                end else if (r_pat == PAT_LAST) begin
                    if (r_seed == SEED_LAST) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_SEED;
                    end
                end else begin
                    w_state_nxt = S_RUN;
                    w_pat_nxt   = r_pat + PW'(1);
                end
            end

            // Round indices advance when leaving SEED, so an abort during
            // the reload cycle freezes the indices of the completed round.
            S_SEED: begin
                if (i_abort) begin
                    w_state_nxt = S_DONE_HI;
                    w_fail_nxt  = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                    w_pat_nxt   = {PW{1'b0}};
                    w_seed_nxt  = r_seed + SW'(1);
                end
            end

            S_FIN: begin
                w_state_nxt = S_DONE_HI;
                w_pass_nxt  = w_sig_match;
                w_fail_nxt  = ~w_sig_match;
            end

            S_DONE_HI: begin
                w_pass_nxt = r_pass;
                w_fail_nxt = r_fail;
                if (!i_start) begin
                    w_state_nxt = S_DONE_LO;
                end else begin
                    w_state_nxt = S_DONE_HI;
                end
            end

            // Re-run goes straight to INIT; the verdict is dropped there.
            S_DONE_LO: begin
                if (i_start) begin
                    w_state_nxt = S_INIT;
                    w_pat_nxt   = {PW{1'b0}};
                    w_seed_nxt  = {SW{1'b0}};
                end else begin
                    w_state_nxt = S_DONE_LO;
                    w_pass_nxt  = r_pass;
                    w_fail_nxt  = r_fail;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_pat_nxt   = {PW{1'b0}};
                w_seed_nxt  = {SW{1'b0}};
            end
        endcase
    end

    // State, counters and outputs registered together; each output is the
    // decode of the state it accompanies, so they change in lock-step.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pat      <= {PW{1'b0}};
            r_seed     <= {SW{1'b0}};
            r_init     <= 1'b0;
            r_running  <= 1'b0;
            r_seed_ld  <= 1'b0;
            r_finish   <= 1'b0;
            r_bist_end <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pat      <= w_pat_nxt;
            r_seed     <= w_seed_nxt;
            r_init     <= (w_state_nxt == S_INIT);
            r_running  <= (w_state_nxt == S_RUN);
            r_seed_ld  <= (w_state_nxt == S_SEED);
            r_finish   <= (w_state_nxt == S_FIN);
            r_bist_end <= (w_state_nxt == S_DONE_HI) || (w_state_nxt == S_DONE_LO);
            r_pass     <= w_pass_nxt;
            r_fail     <= w_fail_nxt;
        end
    end

    assign o_init     = r_init;
    assign o_running  = r_running;
    assign o_seed_ld  = r_seed_ld;
    assign o_finish   = r_finish;
    assign o_bist_end = r_bist_end;
    assign o_pass     = r_pass;
    assign o_fail     = r_fail;
    assign o_pat_idx  = r_pat;
    assign o_seed_idx = r_seed;

endmodule
